// File: rtl/lcd_text_controller.sv
// HD44780 character-LCD controller with an on-chip ROWS x COLS text buffer.
// Runs the panel power-up sequence, then streams the buffer as address/data frames on a divided tick.
module lcd_text_controller #(
    parameter int CLK_HZ       = 50_000_000,
    parameter int TICK_HZ      = 500,
    parameter int ROWS         = 2,
    parameter int COLS         = 16,
    parameter int BUS4         = 0,
    parameter int AUTO_REFRESH = 0,
    localparam int AW          = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
    input  logic          clock50MHz,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          refresh_req,
    output logic          busy,
    output logic          frame_done,
    output logic          RS,
    output logic          RW,
    output logic          E,
    output logic [7:0]    DB,
    output logic          LCD_On,
    output logic          LCD_Blon
);

    localparam int DIV     = CLK_HZ / TICK_HZ;
    localparam int DIVW    = $clog2(DIV);
    localparam int NCHAR   = ROWS * COLS;
    localparam int CW      = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RWID    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int NINIT   = (BUS4 != 0) ? 5 : 4;
    localparam int CLR_IDX = (BUS4 != 0) ? 3 : 2;

    typedef enum logic [2:0] {
        S_PWR_WAIT,
        S_INIT,
        S_INIT_WAIT,
        S_IDLE,
        S_SET_ADDR,
        S_WRITE_CHAR
    } state_t;

    typedef enum logic [1:0] {
        PH_SETUP,
        PH_PULSE,
        PH_HOLD
    } phase_t;

    state_t            state_q, state_d;
    phase_t            phase_q, phase_d;
    logic              nib_q, nib_d;
    logic [4:0]        wait_q, wait_d;
    logic [2:0]        idx_q, idx_d;
    logic [RWID-1:0]   row_q, row_d;
    logic [CW-1:0]     col_q, col_d;
    logic [7:0]        byte_q, byte_d;
    logic              rs_q, rs_d;
    logic              pend_q, pend_d;
    logic              done_q, done_d;
    logic [DIVW-1:0]   div_q, div_d;
    logic [7:0]        buf_q [NCHAR];

    logic              tick;
    logic              byte_end;
    logic              load;
    logic [7:0]        ld_byte;
    logic              ld_rs;
    logic              xfer;

    function automatic logic [7:0] init_cmd(input logic [2:0] idx);
        if (BUS4 != 0) begin
            case (int'(idx))
                0:       return 8'h20;
                1:       return 8'h28;
                2:       return 8'h0C;
                3:       return 8'h01;
                default: return 8'h06;
            endcase
        end
        case (int'(idx))
            0:       return 8'h38;
            1:       return 8'h0C;
            2:       return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

    function automatic logic [7:0] addr_cmd(input logic [RWID-1:0] r);
        case (int'(r))
            0:       return 8'h80;
            1:       return 8'hC0;
            2:       return 8'h94;
            default: return 8'hD4;
        endcase
    endfunction

    function automatic logic [AW-1:0] char_addr(input logic [RWID-1:0] r, input logic [CW-1:0] c);
        int a;
        a = int'(r) * COLS + int'(c);
        return AW'(a);
    endfunction

    assign tick = (div_q == DIVW'(DIV - 1));

    // The lone 0x2 nibble that switches the panel into 4-bit mode has no low half.
    assign byte_end = (phase_q == PH_HOLD) &&
                      ((BUS4 == 0) || nib_q || (state_q == S_INIT && idx_q == 3'd0));

    always_ff @(posedge clock50MHz) begin
        if (reset) begin
            state_q <= S_PWR_WAIT;
            phase_q <= PH_SETUP;
            nib_q   <= 1'b0;
            wait_q  <= '0;
            idx_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            rs_q    <= 1'b0;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
            div_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            nib_q   <= nib_d;
            wait_q  <= wait_d;
            idx_q   <= idx_d;
            row_q   <= row_d;
            col_q   <= col_d;
            rs_q    <= rs_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
            div_q   <= div_d;
        end
        byte_q <= byte_d;
    end

    always_ff @(posedge clock50MHz) begin
        if (reset) begin
            for (int i = 0; i < NCHAR; i++) buf_q[i] <= 8'h20;
        end else if (wr_en && (int'(wr_addr) < NCHAR)) begin
            buf_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        nib_d   = nib_q;
        wait_d  = wait_q;
        idx_d   = idx_q;
        row_d   = row_q;
        col_d   = col_q;
        byte_d  = byte_q;
        rs_d    = rs_q;
        done_d  = 1'b0;
        pend_d  = pend_q | refresh_req;
        div_d   = tick ? '0 : div_q + 1'b1;
        load    = 1'b0;
        ld_byte = byte_q;
        ld_rs   = 1'b0;

        if (tick) begin
            case (state_q)
                S_PWR_WAIT: begin
                    if (wait_q == 5'd19) begin
                        state_d = S_INIT;
                        idx_d   = 3'd0;
                        load    = 1'b1;
                        ld_byte = init_cmd(3'd0);
                    end else begin
                        wait_d = wait_q + 5'd1;
                    end
                end
                S_INIT_WAIT: begin
                    if (wait_q == 5'd1) begin
                        state_d = S_INIT;
                        idx_d   = idx_q + 3'd1;
                        load    = 1'b1;
                        ld_byte = init_cmd(idx_q + 3'd1);
                    end else begin
                        wait_d = wait_q + 5'd1;
                    end
                end
                S_IDLE: begin
                    if (refresh_req || pend_q || (AUTO_REFRESH != 0)) begin
                        state_d = S_SET_ADDR;
                        row_d   = '0;
                        col_d   = '0;
                        pend_d  = 1'b0;
                        load    = 1'b1;
                        ld_byte = addr_cmd('0);
                    end
                end
                default: begin
                    case (phase_q)
                        PH_SETUP: phase_d = PH_PULSE;
                        PH_PULSE: phase_d = PH_HOLD;
                        default: begin
                            if (!byte_end) begin
                                phase_d = PH_SETUP;
                                nib_d   = 1'b1;
                            end else if (state_q == S_INIT) begin
                                if (idx_q == 3'(CLR_IDX)) begin
                                    state_d = S_INIT_WAIT;
                                    wait_d  = '0;
                                end else if (idx_q == 3'(NINIT - 1)) begin
                                    state_d = S_SET_ADDR;
                                    row_d   = '0;
                                    col_d   = '0;
                                    load    = 1'b1;
                                    ld_byte = addr_cmd('0);
                                end else begin
                                    idx_d   = idx_q + 3'd1;
                                    load    = 1'b1;
                                    ld_byte = init_cmd(idx_q + 3'd1);
                                end
                            end else if (state_q == S_SET_ADDR) begin
                                state_d = S_WRITE_CHAR;
                                col_d   = '0;
                                load    = 1'b1;
                                ld_rs   = 1'b1;
                                ld_byte = buf_q[char_addr(row_q, CW'(0))];
                            end else if (col_q != CW'(COLS - 1)) begin
                                col_d   = col_q + 1'b1;
                                load    = 1'b1;
                                ld_rs   = 1'b1;
                                ld_byte = buf_q[char_addr(row_q, col_q + 1'b1)];
                            end else if (row_q != RWID'(ROWS - 1)) begin
                                state_d = S_SET_ADDR;
                                row_d   = row_q + 1'b1;
                                col_d   = '0;
                                load    = 1'b1;
                                ld_byte = addr_cmd(row_q + 1'b1);
                            end else begin
                                state_d = S_IDLE;
                                row_d   = '0;
                                col_d   = '0;
                                done_d  = 1'b1;
                            end
                        end
                    endcase
                end
            endcase
        end

        // Characters are sampled here, so a same-cycle write to this entry is seen next frame.
        if (load) begin
            phase_d = PH_SETUP;
            nib_d   = 1'b0;
            byte_d  = ld_byte;
            rs_d    = ld_rs;
        end
    end

    always_comb begin
        xfer       = (state_q == S_INIT) || (state_q == S_SET_ADDR) || (state_q == S_WRITE_CHAR);
        E          = xfer && (phase_q == PH_PULSE);
        RS         = xfer && rs_q;
        DB         = 8'h00;
        if (xfer) begin
            DB = (BUS4 != 0) ? {(nib_q ? byte_q[3:0] : byte_q[7:4]), 4'h0} : byte_q;
        end
        busy       = (state_q != S_IDLE);
        frame_done = done_q;
        RW         = 1'b0;
        LCD_On     = 1'b1;
        LCD_Blon   = 1'b1;
    end

endmodule

// File: tb/tb_lcd_text_controller.sv
// Bench for lcd_text_controller: an 8-bit 2x16 instance and a 4-bit 1x3 instance,
// with every E strobe popped from an expected-transfer queue.
module tb_lcd_text_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, wr_en, refresh_req;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy, frame_done, RS, RWo, E, LCD_On, LCD_Blon;
    logic [7:0] DB;

    logic       rst4, wr_en4, refresh_req4;
    logic [1:0] wr_addr4;
    logic [7:0] wr_data4;
    logic       busy4, frame_done4, RS4, RW4, E4, LCD_On4, LCD_Blon4;
    logic [7:0] DB4;

    lcd_text_controller #(.CLK_HZ(1000), .TICK_HZ(500), .ROWS(2), .COLS(16),
                          .BUS4(0), .AUTO_REFRESH(0)) u8 (
        .clock50MHz(clk), .reset(rst), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .refresh_req(refresh_req), .busy(busy),
        .frame_done(frame_done), .RS(RS), .RW(RWo), .E(E), .DB(DB),
        .LCD_On(LCD_On), .LCD_Blon(LCD_Blon)
    );

    lcd_text_controller #(.CLK_HZ(1000), .TICK_HZ(500), .ROWS(1), .COLS(3),
                          .BUS4(1), .AUTO_REFRESH(0)) u4 (
        .clock50MHz(clk), .reset(rst4), .wr_en(wr_en4), .wr_addr(wr_addr4),
        .wr_data(wr_data4), .refresh_req(refresh_req4), .busy(busy4),
        .frame_done(frame_done4), .RS(RS4), .RW(RW4), .E(E4), .DB(DB4),
        .LCD_On(LCD_On4), .LCD_Blon(LCD_Blon4)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, expv);
        end
    endtask

    task automatic fail_now(input string nm, input logic [31:0] act);
        n_chk++;
        n_err++;
        $display("FAIL %s: got 0x%0h, want no transfer", nm, act);
    endtask

    // Expected {RS, DB} per E strobe of the 8-bit instance, {RS, DB[7:4]} for the 4-bit one.
    logic [8:0] exp_q [$];
    logic [4:0] q4 [$];
    logic [7:0] mdl [32];

    int         pulse_cnt = 0;
    int         done_cnt  = 0;
    int         done4_cnt = 0;
    logic       e_prev    = 1'b0;
    logic       e4_prev   = 1'b0;
    logic [8:0] held      = '0;
    logic [4:0] held4     = '0;
    logic [8:0] pop8;
    logic [4:0] pop4;

    always @(negedge clk) begin
        if (E && !e_prev) begin
            pulse_cnt <= pulse_cnt + 1;
            held      <= {RS, DB};
            if (exp_q.size() == 0) begin
                fail_now("unexpected_pulse8", {23'd0, RS, DB});
            end else begin
                pop8 = exp_q.pop_front();
                chk("pulse8", {23'd0, RS, DB}, {23'd0, pop8});
            end
        end
        if (!E && e_prev && !rst) chk("hold_stable8", {23'd0, RS, DB}, {23'd0, held});
        if (frame_done) done_cnt <= done_cnt + 1;
        e_prev <= E;
    end

    always @(negedge clk) begin
        if (E4 && !e4_prev) begin
            held4 <= {RS4, DB4[7:4]};
            chk("bus4_low_nibble", {28'd0, DB4[3:0]}, 32'd0);
            if (q4.size() == 0) begin
                fail_now("unexpected_pulse4", {27'd0, RS4, DB4[7:4]});
            end else begin
                pop4 = q4.pop_front();
                chk("pulse4", {27'd0, RS4, DB4[7:4]}, {27'd0, pop4});
            end
        end
        if (!E4 && e4_prev && !rst4) chk("hold_stable4", {27'd0, RS4, DB4[7:4]}, {27'd0, held4});
        if (frame_done4) done4_cnt <= done4_cnt + 1;
        e4_prev <= E4;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [4:0] addr;
        logic [7:0] data;
        int         pos;
        logic [8:0] expv;
    } vec_t;

    vec_t       tbl [4];
    logic [8:0] fr [34];

    task automatic wr8(input logic [4:0] a, input logic [7:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic refresh8();
        @(negedge clk);
        refresh_req = 1'b1;
        @(negedge clk);
        refresh_req = 1'b0;
    endtask

    task automatic push_init8();
        exp_q.push_back(9'h038);
        exp_q.push_back(9'h00C);
        exp_q.push_back(9'h001);
        exp_q.push_back(9'h006);
    endtask

    task automatic push_frame8();
        exp_q.push_back(9'h080);
        for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, mdl[i]});
        exp_q.push_back(9'h0C0);
        for (int i = 16; i < 32; i++) exp_q.push_back({1'b1, mdl[i]});
    endtask

    task automatic wait_done8(input string nm, input int target, input int budget);
        int k = 0;
        while (done_cnt < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(nm, done_cnt >= target, 1);
    endtask

    task automatic wait_done4(input string nm, input int target, input int budget);
        int k = 0;
        while (done4_cnt < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(nm, done4_cnt >= target, 1);
    endtask

    task automatic wait_pulses8(input string nm, input int target, input int budget);
        int k = 0;
        while (pulse_cnt < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(nm, pulse_cnt >= target, 1);
    endtask

    task automatic check_e_low_40(input string nm);
        int lows = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (E === 1'b0) lows++;
        end
        chk(nm, lows, 40);
    endtask

    int p_base;
    int d_base;

    initial begin
        tbl[0] = '{5'd0,  8'h48, 1,  {1'b1, 8'h48}};
        tbl[1] = '{5'd17, 8'h49, 19, {1'b1, 8'h49}};
        tbl[2] = '{5'd15, 8'h5A, 16, {1'b1, 8'h5A}};
        tbl[3] = '{5'd31, 8'h7E, 33, {1'b1, 8'h7E}};
        for (int i = 0; i < 32; i++) mdl[i] = 8'h20;

        rst = 1'b1; wr_en = 1'b0; refresh_req = 1'b0; wr_addr = '0; wr_data = '0;
        rst4 = 1'b1; wr_en4 = 1'b0; refresh_req4 = 1'b0; wr_addr4 = '0; wr_data4 = '0;

        // Power-up in both bus modes.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_E", E, 0);
        chk("rst_RS", RS, 0);
        chk("rst_DB", DB, 0);
        chk("rst_busy", busy, 1);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_RW_on_blon", {RWo, LCD_On, LCD_Blon}, 3'b011);
        chk("rst_busy4", busy4, 1);
        push_init8();
        push_frame8();
        foreach (q4[i]) q4.delete(i);
        q4.push_back(5'h02);
        q4.push_back(5'h02); q4.push_back(5'h08);
        q4.push_back(5'h00); q4.push_back(5'h0C);
        q4.push_back(5'h00); q4.push_back(5'h01);
        q4.push_back(5'h00); q4.push_back(5'h06);
        q4.push_back(5'h08); q4.push_back(5'h00);
        for (int i = 0; i < 3; i++) begin
            q4.push_back(5'h12); q4.push_back(5'h10);
        end
        @(negedge clk);
        rst = 1'b0; rst4 = 1'b0;
        p_base = pulse_cnt;
        check_e_low_40("pwr_wait_e_low");
        wait_done8("t1_frame_done", 1, 3000);
        repeat (2) @(negedge clk);
        chk("t1_busy_idle", busy, 0);
        chk("t1_done_once", done_cnt, 1);
        chk("t1_pulses", pulse_cnt - p_base, 38);
        chk("t1_queue_drained", exp_q.size(), 0);

        wait_done4("t5_frame_done", 1, 3000);
        repeat (2) @(negedge clk);
        chk("t5_queue_drained", q4.size(), 0);
        chk("t5_busy4_idle", busy4, 0);
        // Out-of-range address 3 must leave the 3-entry buffer untouched.
        @(negedge clk); wr_en4 = 1'b1; wr_addr4 = 2'd3; wr_data4 = 8'h41;
        @(negedge clk); wr_addr4 = 2'd1; wr_data4 = 8'h5A;
        @(negedge clk); wr_en4 = 1'b0;
        q4.push_back(5'h08); q4.push_back(5'h00);
        q4.push_back(5'h12); q4.push_back(5'h10);
        q4.push_back(5'h15); q4.push_back(5'h1A);
        q4.push_back(5'h12); q4.push_back(5'h10);
        @(negedge clk); refresh_req4 = 1'b1;
        @(negedge clk); refresh_req4 = 1'b0;
        wait_done4("t5_oor_frame_done", 2, 3000);
        repeat (2) @(negedge clk);
        chk("t5_oor_queue_drained", q4.size(), 0);

        // Table-driven buffer writes, then one refresh.
        for (int i = 0; i < 34; i++) fr[i] = 9'h120;
        fr[0]  = 9'h080;
        fr[17] = 9'h0C0;
        for (int i = 0; i < 4; i++) begin
            wr8(tbl[i].addr, tbl[i].data);
            mdl[tbl[i].addr] = tbl[i].data;
            fr[tbl[i].pos] = tbl[i].expv;
        end
        for (int i = 0; i < 34; i++) exp_q.push_back(fr[i]);
        p_base = pulse_cnt;
        d_base = done_cnt;
        refresh8();
        wait_done8("t2_frame_done", d_base + 1, 3000);
        repeat (2) @(negedge clk);
        chk("t2_pulses", pulse_cnt - p_base, 34);
        chk("t2_done_once", done_cnt - d_base, 1);
        chk("t2_queue_drained", exp_q.size(), 0);

        // Mid-frame writes: col 2 already sent, col 10 not yet sampled.
        mdl[10] = 8'h41;
        push_frame8();
        mdl[2] = 8'h41;
        p_base = pulse_cnt;
        d_base = done_cnt;
        refresh8();
        wait_pulses8("t3_reach_char5", p_base + 6, 2000);
        wr8(5'd2, 8'h41);
        wr8(5'd10, 8'h41);
        wait_done8("t3_frame_done", d_base + 1, 3000);
        push_frame8();
        refresh8();
        wait_done8("t3_next_frame_done", d_base + 2, 3000);
        repeat (2) @(negedge clk);
        chk("t3_queue_drained", exp_q.size(), 0);

        // Three requests during one busy frame collapse into one extra frame.
        push_frame8();
        push_frame8();
        d_base = done_cnt;
        p_base = pulse_cnt;
        refresh8();
        wait_pulses8("t4_frame_started", p_base + 3, 2000);
        chk("t4_busy_in_frame", busy, 1);
        for (int i = 0; i < 3; i++) begin
            refresh8();
            repeat (5) @(negedge clk);
        end
        wait_done8("t4_two_frames", d_base + 2, 4000);
        repeat (150) @(negedge clk);
        chk("t4_busy_idle", busy, 0);
        chk("t4_exactly_two", done_cnt - d_base, 2);
        chk("t4_pulses", pulse_cnt - p_base, 68);
        chk("t4_queue_drained", exp_q.size(), 0);

        // Reset while character 7 of row 0 is strobing.
        push_frame8();
        p_base = pulse_cnt;
        refresh8();
        wait_pulses8("t6_reach_char7", p_base + 8, 2000);
        chk("t6_e_high_at_reset", E, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_E", E, 0);
        chk("t6_DB", DB, 0);
        chk("t6_RS", RS, 0);
        chk("t6_busy", busy, 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 32; i++) mdl[i] = 8'h20;
        push_init8();
        push_frame8();
        d_base = done_cnt;
        p_base = pulse_cnt;
        check_e_low_40("t6_pwr_wait_e_low");
        wait_done8("t6_frame_done", d_base + 1, 3000);
        repeat (2) @(negedge clk);
        chk("t6_pulses", pulse_cnt - p_base, 38);
        chk("t6_queue_drained", exp_q.size(), 0);
        chk("t6_busy_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
